// File: rtl/holder_array.sv
// holder_array: per-channel pulse stretchers with shared hold/cooldown timing
module holder_array #(
  parameter int CHANNELS  = 4,
  parameter int HOLD_TIME = 1,
  parameter int COOLDOWN  = 0,
  parameter int CNT_W     = 26,
  parameter int RETRIGGER = 1,
  parameter int EDGE_TRIG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] signal_in,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] signal_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] expired
);
  typedef enum logic [1:0] {IDLE, HOLD, COOL} state_t;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN > 0 ? COOLDOWN - 1 : 0);
  logic [CHANNELS-1:0] in_d, trig;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) in_d <= '0;
    else in_d <= signal_in;
  assign trig = {CHANNELS{enable}} & (EDGE_TRIG != 0 ? signal_in & ~in_d : signal_in);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t st;
    logic [CNT_W-1:0] cnt;
    logic so, bo, eo;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st  <= IDLE;
        cnt <= '0;
        so  <= 1'b0;
        bo  <= 1'b0;
        eo  <= 1'b0;
      end else begin
        eo <= 1'b0;
        if (clear[c]) begin
          st  <= IDLE;
          cnt <= '0;
          so  <= 1'b0;
          bo  <= 1'b0;
        end else begin
          unique case (st)
            IDLE:
              if (trig[c]) begin
                st  <= HOLD;
                cnt <= HOLD_LD;
                so  <= 1'b1;
                bo  <= 1'b1;
              end
            HOLD:
              if (RETRIGGER != 0 && trig[c]) cnt <= HOLD_LD;
              else if (cnt == '0) begin
                so <= 1'b0;
                eo <= 1'b1;
                if (COOLDOWN > 0) begin
                  st  <= COOL;
                  cnt <= COOL_LD;
                end else begin
                  st <= IDLE;
                  bo <= 1'b0;
                end
              end else cnt <= cnt - 1'b1;
            COOL:
              if (cnt == '0) begin
                st <= IDLE;
                bo <= 1'b0;
              end else cnt <= cnt - 1'b1;
            default: begin
              st <= IDLE;
              bo <= 1'b0;
            end
          endcase
        end
      end
    assign signal_out[c] = so;
    assign busy[c]       = bo;
    assign expired[c]    = eo;
  end
endmodule

// File: tb/tb_holder_array.sv
// tb_holder_array: directed scoreboard bench over six holder_array configurations
module tb_holder_array;
  logic clk = 0, rst_n = 1, en = 1;
  logic [3:0] sin = '0, clr = '0;
  logic [3:0] so[6], bo[6], eo[6];
  int ncmp = 0, nerr = 0;
  typedef struct {int k; logic [3:0] s; logic [3:0] b; logic [3:0] e; string tag;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  holder_array #(.CHANNELS(4), .HOLD_TIME(5), .COOLDOWN(0), .CNT_W(8), .RETRIGGER(0), .EDGE_TRIG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en), .signal_in(sin), .clear(clr),
    .signal_out(so[0]), .busy(bo[0]), .expired(eo[0]));
  holder_array #(.CHANNELS(4), .HOLD_TIME(5), .COOLDOWN(0), .CNT_W(8), .RETRIGGER(1), .EDGE_TRIG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en), .signal_in(sin), .clear(clr),
    .signal_out(so[1]), .busy(bo[1]), .expired(eo[1]));
  holder_array #(.CHANNELS(4), .HOLD_TIME(2), .COOLDOWN(3), .CNT_W(8), .RETRIGGER(0), .EDGE_TRIG(0)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(en), .signal_in(sin), .clear(clr),
    .signal_out(so[2]), .busy(bo[2]), .expired(eo[2]));
  holder_array #(.CHANNELS(4), .HOLD_TIME(4), .COOLDOWN(0), .CNT_W(8), .RETRIGGER(1), .EDGE_TRIG(1)) u3 (
    .clk(clk), .rst_n(rst_n), .enable(en), .signal_in(sin), .clear(clr),
    .signal_out(so[3]), .busy(bo[3]), .expired(eo[3]));
  holder_array #(.CHANNELS(4), .HOLD_TIME(8), .COOLDOWN(0), .CNT_W(8), .RETRIGGER(1), .EDGE_TRIG(0)) u4 (
    .clk(clk), .rst_n(rst_n), .enable(en), .signal_in(sin), .clear(clr),
    .signal_out(so[4]), .busy(bo[4]), .expired(eo[4]));
  holder_array #(.CHANNELS(4), .HOLD_TIME(1), .COOLDOWN(0), .CNT_W(8), .RETRIGGER(1), .EDGE_TRIG(0)) u5 (
    .clk(clk), .rst_n(rst_n), .enable(en), .signal_in(sin), .clear(clr),
    .signal_out(so[5]), .busy(bo[5]), .expired(eo[5]));

  task automatic push(input int k, input logic [3:0] s, input logic [3:0] b, input logic [3:0] e, input string tag);
    exp_t x;
    x.k = k; x.s = s; x.b = b; x.e = e; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic chk();
    exp_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      ncmp++;
      assert (so[x.k] === x.s) else begin
        nerr++;
        $error("FAIL %s u%0d signal_out got %b expected %b", x.tag, x.k, so[x.k], x.s);
      end
      ncmp++;
      assert (bo[x.k] === x.b) else begin
        nerr++;
        $error("FAIL %s u%0d busy got %b expected %b", x.tag, x.k, bo[x.k], x.b);
      end
      ncmp++;
      assert (eo[x.k] === x.e) else begin
        nerr++;
        $error("FAIL %s u%0d expired got %b expected %b", x.tag, x.k, eo[x.k], x.e);
      end
    end
  endtask

  task automatic cyc(input int k, input logic [3:0] s, input logic [3:0] b, input logic [3:0] e, input string tag);
    push(k, s, b, e, tag);
    @(posedge clk);
    #1;
    chk();
  endtask

  task automatic rst_all(input string tag);
    rst_n = 0;
    sin = '0;
    clr = '0;
    #2;
    for (int k = 0; k < 6; k++) push(k, 4'h0, 4'h0, 4'h0, tag);
    chk();
    rst_n = 1;
  endtask

  initial begin
    #1;
    rst_all("reset");
    // one-shot hold, mid-hold trigger ignored
    sin = 4'h1; cyc(0, 4'h1, 4'h1, 4'h0, "t1_start");
    sin = 4'h0; cyc(0, 4'h1, 4'h1, 4'h0, "t1_hold");
    sin = 4'h1; cyc(0, 4'h1, 4'h1, 4'h0, "t1_noretrig");
    sin = 4'h0; repeat (2) cyc(0, 4'h1, 4'h1, 4'h0, "t1_hold");
    cyc(0, 4'h0, 4'h0, 4'h1, "t1_expired");
    cyc(0, 4'h0, 4'h0, 4'h0, "t1_idle");
    rst_all("t1b_reset");
    sin = 4'h1; cyc(0, 4'h1, 4'h1, 4'h0, "t1b_start");
    sin = 4'h0; repeat (4) cyc(0, 4'h1, 4'h1, 4'h0, "t1b_hold");
    sin = 4'h1; cyc(0, 4'h0, 4'h0, 4'h1, "t1b_trig_on_expiry");
    sin = 4'h0; cyc(0, 4'h0, 4'h0, 4'h0, "t1b_ignored");
    // retrigger extension
    rst_all("t2_reset");
    sin = 4'h1; cyc(1, 4'h1, 4'h1, 4'h0, "t2_start");
    sin = 4'h0; repeat (2) cyc(1, 4'h1, 4'h1, 4'h0, "t2_hold");
    sin = 4'h1; cyc(1, 4'h1, 4'h1, 4'h0, "t2_retrig");
    sin = 4'h0; repeat (4) cyc(1, 4'h1, 4'h1, 4'h0, "t2_ext");
    cyc(1, 4'h0, 4'h0, 4'h1, "t2_expired");
    cyc(1, 4'h0, 4'h0, 4'h0, "t2_idle");
    rst_all("t2b_reset");
    sin = 4'h1; cyc(1, 4'h1, 4'h1, 4'h0, "t2b_start");
    sin = 4'h0; repeat (4) cyc(1, 4'h1, 4'h1, 4'h0, "t2b_hold");
    sin = 4'h1; cyc(1, 4'h1, 4'h1, 4'h0, "t2b_reload_on_expiry");
    sin = 4'h0; repeat (4) cyc(1, 4'h1, 4'h1, 4'h0, "t2b_ext");
    cyc(1, 4'h0, 4'h0, 4'h1, "t2b_expired");
    rst_all("t2c_reset");
    sin = 4'h1; cyc(1, 4'h1, 4'h1, 4'h0, "t2c_start");
    en = 0; repeat (4) cyc(1, 4'h1, 4'h1, 4'h0, "t2c_en_off_hold");
    cyc(1, 4'h0, 4'h0, 4'h1, "t2c_expired");
    cyc(1, 4'h0, 4'h0, 4'h0, "t2c_no_trig");
    en = 1;
    // one-shot level with cooldown, all channels
    rst_all("t3_reset");
    sin = 4'hF;
    repeat (3) begin
      cyc(2, 4'hF, 4'hF, 4'h0, "t3_hi");
      cyc(2, 4'hF, 4'hF, 4'h0, "t3_hi");
      cyc(2, 4'h0, 4'hF, 4'hF, "t3_exp");
      cyc(2, 4'h0, 4'hF, 4'h0, "t3_cool");
      cyc(2, 4'h0, 4'hF, 4'h0, "t3_cool");
      cyc(2, 4'h0, 4'h0, 4'h0, "t3_idle");
    end
    cyc(2, 4'hF, 4'hF, 4'h0, "t3_hi");
    cyc(2, 4'hF, 4'hF, 4'h0, "t3_hi");
    cyc(2, 4'h0, 4'hF, 4'hF, "t3_exp");
    rst_all("t6_rst_cool");
    cyc(2, 4'h0, 4'h0, 4'h0, "t6_after_rst_cool");
    // edge trigger with input held high
    rst_all("t4_reset");
    sin = 4'h1; repeat (4) cyc(3, 4'h1, 4'h1, 4'h0, "t4_hold");
    cyc(3, 4'h0, 4'h0, 4'h1, "t4_expired");
    repeat (15) cyc(3, 4'h0, 4'h0, 4'h0, "t4_held_no_retrig");
    sin = 4'h0; cyc(3, 4'h0, 4'h0, 4'h0, "t4_release");
    sin = 4'h1; cyc(3, 4'h1, 4'h1, 4'h0, "t4_new_edge");
    // clear on channel 1 with same-edge trigger
    rst_all("t5_reset");
    sin = 4'h3; cyc(4, 4'h3, 4'h3, 4'h0, "t5_start");
    sin = 4'h0; cyc(4, 4'h3, 4'h3, 4'h0, "t5_hold");
    sin = 4'h2; clr = 4'h2; cyc(4, 4'h1, 4'h1, 4'h0, "t5_clear");
    sin = 4'h0; clr = 4'h0; cyc(4, 4'h1, 4'h1, 4'h0, "t5_after_clear");
    sin = 4'h2; cyc(4, 4'h3, 4'h3, 4'h0, "t5_restart");
    sin = 4'h0; repeat (3) cyc(4, 4'h3, 4'h3, 4'h0, "t5_hold2");
    cyc(4, 4'h2, 4'h2, 4'h1, "t5_ch0_expired");
    repeat (3) cyc(4, 4'h2, 4'h2, 4'h0, "t5_ch1_hold");
    cyc(4, 4'h0, 4'h0, 4'h2, "t5_ch1_expired");
    cyc(4, 4'h0, 4'h0, 4'h0, "t5_idle");
    // async reset mid-hold, enable gating, single-cycle hold
    rst_all("t6_reset");
    sin = 4'h1; cyc(0, 4'h1, 4'h1, 4'h0, "t6_start");
    sin = 4'h0; cyc(0, 4'h1, 4'h1, 4'h0, "t6_hold");
    rst_all("t6_rst_hold");
    cyc(0, 4'h0, 4'h0, 4'h0, "t6_after_rst_hold");
    en = 0; sin = 4'hF;
    repeat (3) cyc(5, 4'h0, 4'h0, 4'h0, "t6_disabled");
    en = 1; sin = 4'h1; cyc(5, 4'h1, 4'h1, 4'h0, "t6_pulse");
    sin = 4'h0; cyc(5, 4'h0, 4'h0, 4'h1, "t6_expired");
    cyc(5, 4'h0, 4'h0, 4'h0, "t6_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
